// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_pkg
// Description : Shared definitions for the FIFO, its writer and its read
//               controller: default sizing constants, counter widths and the
//               read-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BURST_LEN   = 16;
  localparam int DEF_IDLE_CYCLES = 2;

  // word_count output width (covers BURST_LEN up to 1023)
  localparam int WORD_CNT_W = 10;
  // inter-read gap counter width (covers IDLE_CYCLES up to 15)
  localparam int GAP_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAPT = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/rd_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : rd_gap_timer
// Description : Loadable down-counter that times the idle gap between two
//               FIFO reads. done is high on the last cycle of the gap, so a
//               load value of N keeps the controller in GAP for N cycles.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               load       - load load_value into the counter
//               load_value - gap length in cycles
//               enable     - count down (controller is in GAP)
//               done       - gap expires this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rd_gap_timer
  import fifo_pkg::*;
#(
  parameter int WIDTH = GAP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A zero count also reads as done so the controller can never stick in GAP.
  assign done = (count == '0) || (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_ctrl
// Description : Drains one burst of BURST_LEN words from a FIFO per start
//               command, one word in flight at a time, with IDLE_CYCLES idle
//               cycles between consecutive reads and a valid/ready output.
// Ports       : rd_clk     - read-domain clock, rising edge
//               rd_rst     - asynchronous active-high reset
//               start      - one-cycle burst request, sampled only in IDLE
//               fifo_empty - FIFO empty flag
//               fifo_data  - FIFO read data, valid the cycle after fifo_read
//               fifo_read  - FIFO read strobe
//               out_data   - registered output word
//               out_valid  - out_data holds an unconsumed word
//               out_ready  - downstream accepts the word
//               busy       - burst in progress
//               done       - one-cycle pulse after the final handshake
//               word_count - words accepted in the current burst
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam logic [WORD_CNT_W-1:0] LAST_COUNT = WORD_CNT_W'(BURST_LEN - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LOAD   = GAP_CNT_W'(IDLE_CYCLES);
  localparam logic                  HAS_GAP    = (IDLE_CYCLES > 0);

  rd_state_e state;
  logic      handshake;
  logic      last_word;
  logic      gap_load;
  logic      gap_done;

  // Reading only from REQ keeps at most one word in flight; an empty flag
  // seen in any other state is simply irrelevant.
  assign fifo_read = (state == ST_REQ) && !fifo_empty;
  assign handshake = (state == ST_HOLD) && out_valid && out_ready;
  assign last_word = (word_count == LAST_COUNT);
  assign gap_load  = handshake && !last_word && HAS_GAP;

  rd_gap_timer #(
    .WIDTH(GAP_CNT_W)
  ) u_gap_timer (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .load      (gap_load),
    .load_value(GAP_LOAD),
    .enable    (state == ST_GAP),
    .done      (gap_done)
  );

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= ST_IDLE;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // word_count keeps the previous burst's total until a new start.
          if (start) begin
            state      <= ST_REQ;
            word_count <= '0;
            busy       <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!fifo_empty) begin
            state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          out_data  <= fifo_data;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (handshake) begin
            out_valid  <= 1'b0;
            word_count <= word_count + 1'b1;
            if (last_word) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (HAS_GAP) begin
              state <= ST_GAP;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state <= ST_REQ;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_ctrl
// Description : Self-checking bench for fifo_read_ctrl. Instance A uses
//               BURST_LEN=4/IDLE_CYCLES=2, instance B BURST_LEN=3/
//               IDLE_CYCLES=0. Each has a FIFO model and a scoreboard of
//               expected words checked on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;
  import fifo_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A ----------------
  logic          start_a, force_empty_a, fifo_empty_a, fifo_read_a;
  logic [DW-1:0] fifo_data_a = '0;
  logic [DW-1:0] out_data_a;
  logic          out_valid_a, out_ready_a, busy_a, done_a;
  logic [9:0]    wc_a;
  logic [DW-1:0] mem_a[$];
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_w_a;
  int            push_cnt_a = 0;
  int            pop_cnt_a  = 0;
  int            rd_cyc_a[$];
  int            hs_cyc_a[$];
  int            done_cyc_a[$];
  int            viol_a = 0;

  assign fifo_empty_a = force_empty_a || (push_cnt_a == pop_cnt_a);

  fifo_read_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(4), .IDLE_CYCLES(2)) u_dut_a (
    .rd_clk(clk), .rd_rst(rst), .start(start_a), .fifo_empty(fifo_empty_a),
    .fifo_data(fifo_data_a), .fifo_read(fifo_read_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a),
    .done(done_a), .word_count(wc_a)
  );

  always @(posedge clk) begin
    if (fifo_read_a) begin
      pop_cnt_a <= pop_cnt_a + 1;
      if (mem_a.size() != 0) fifo_data_a <= mem_a.pop_front();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_read_a) begin
        rd_cyc_a.push_back(cyc);
        if (fifo_empty_a) viol_a++;
      end
      if (out_valid_a && out_ready_a) begin
        hs_cyc_a.push_back(cyc);
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL sb_a_extra: got out_data %h, no word expected", out_data_a);
        end else begin
          exp_w_a = exp_a.pop_front();
          if (out_data_a !== exp_w_a) begin
            n_err++;
            $display("FAIL sb_a_data: got out_data %h, required %h", out_data_a, exp_w_a);
          end
        end
      end
      if (done_a) done_cyc_a.push_back(cyc);
    end
  end

  // ---------------- instance B ----------------
  logic          start_b, fifo_empty_b, fifo_read_b;
  logic [DW-1:0] fifo_data_b = '0;
  logic [DW-1:0] out_data_b;
  logic          out_valid_b, out_ready_b, busy_b, done_b;
  logic [9:0]    wc_b;
  logic [DW-1:0] mem_b[$];
  logic [DW-1:0] exp_b[$];
  logic [DW-1:0] exp_w_b;
  int            push_cnt_b = 0;
  int            pop_cnt_b  = 0;
  int            rd_cyc_b[$];
  int            hs_cyc_b[$];
  int            done_cyc_b[$];
  int            viol_b = 0;

  assign fifo_empty_b = (push_cnt_b == pop_cnt_b);

  fifo_read_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(3), .IDLE_CYCLES(0)) u_dut_b (
    .rd_clk(clk), .rd_rst(rst), .start(start_b), .fifo_empty(fifo_empty_b),
    .fifo_data(fifo_data_b), .fifo_read(fifo_read_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b),
    .done(done_b), .word_count(wc_b)
  );

  always @(posedge clk) begin
    if (fifo_read_b) begin
      pop_cnt_b <= pop_cnt_b + 1;
      if (mem_b.size() != 0) fifo_data_b <= mem_b.pop_front();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_read_b) begin
        rd_cyc_b.push_back(cyc);
        if (fifo_empty_b) viol_b++;
      end
      if (out_valid_b && out_ready_b) begin
        hs_cyc_b.push_back(cyc);
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_err++;
          $display("FAIL sb_b_extra: got out_data %h, no word expected", out_data_b);
        end else begin
          exp_w_b = exp_b.pop_front();
          if (out_data_b !== exp_w_b) begin
            n_err++;
            $display("FAIL sb_b_data: got out_data %h, required %h", out_data_b, exp_w_b);
          end
        end
      end
      if (done_b) done_cyc_b.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [DW-1:0] w);
    mem_a.push_back(w);
    exp_a.push_back(w);
    push_cnt_a = push_cnt_a + 1;
  endtask

  task automatic load_b(input logic [DW-1:0] w, input bit expected);
    mem_b.push_back(w);
    if (expected) exp_b.push_back(w);
    push_cnt_b = push_cnt_b + 1;
  endtask

  task automatic clear_rec_a();
    rd_cyc_a.delete();
    hs_cyc_a.delete();
    done_cyc_a.delete();
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    int k = 0;
    while (done_cyc_a.size() == 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (done_cyc_a.size() == 0) begin
      n_err++;
      $display("FAIL %s_timeout: done count 0 after %0d cycles, required 1", tag, budget);
    end
  endtask

  task automatic wait_valid_a(input int budget, input string tag);
    int k = 0;
    while (!out_valid_a && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!out_valid_a) begin
      n_err++;
      $display("FAIL %s_timeout: out_valid %b after %0d cycles, required 1", tag, out_valid_a, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({fifo_read_a, out_valid_a, busy_a, done_a} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_a_flags: got %b, required 0000", {fifo_read_a, out_valid_a, busy_a, done_a});
    end
    n_cmp++;
    if (out_data_a !== 8'h00) begin
      n_err++;
      $display("FAIL reset_a_data: got %h, required 00", out_data_a);
    end
    n_cmp++;
    if (wc_a !== 10'd0) begin
      n_err++;
      $display("FAIL reset_a_wc: got %0d, required 0", wc_a);
    end
    n_cmp++;
    if ({fifo_read_b, out_valid_b, busy_b, done_b, wc_b} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_b_all: got %b, required 0", {fifo_read_b, out_valid_b, busy_b, done_b, wc_b});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    bit ok;
    clear_rec_a();
    load_a(8'h11); load_a(8'h22); load_a(8'h33); load_a(8'h44);
    out_ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1 || wc_a !== 10'd0) begin
      n_err++;
      $display("FAIL burst_start: busy %b wc %0d, required busy 1 wc 0", busy_a, wc_a);
    end
    wait_done_a(100, "burst");
    n_cmp++;
    if (wc_a !== 10'd4) begin
      n_err++;
      $display("FAIL burst_wc: got %0d, required 4", wc_a);
    end
    ok = (rd_cyc_a.size() == 4);
    if (ok) for (int i = 1; i < 4; i++) if (rd_cyc_a[i] - rd_cyc_a[i-1] != 5) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL burst_read_spacing: %0d reads, required 4 reads 5 cycles apart", rd_cyc_a.size());
    end
    n_cmp++;
    if (rd_cyc_a.size() < 1 || hs_cyc_a.size() < 1 || hs_cyc_a[0] - rd_cyc_a[0] != 2) begin
      n_err++;
      $display("FAIL burst_latency: read-to-valid not observed as 2 cycles (reads %0d, handshakes %0d)",
               rd_cyc_a.size(), hs_cyc_a.size());
    end
    n_cmp++;
    if (hs_cyc_a.size() != 4 || done_cyc_a.size() < 1 || done_cyc_a[0] != hs_cyc_a[3] + 1) begin
      n_err++;
      $display("FAIL burst_done_timing: handshakes %0d, done not one cycle after 4th, required 4 and +1",
               hs_cyc_a.size());
    end
    tick();
    n_cmp++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || wc_a !== 10'd4) begin
      n_err++;
      $display("FAIL burst_after: done %b busy %b wc %0d, required 0 0 4", done_a, busy_a, wc_a);
    end
    n_cmp++;
    if (exp_a.size() != 0) begin
      n_err++;
      $display("FAIL burst_left: %0d words undelivered, required 0", exp_a.size());
    end
  endtask

  task automatic test_empty_stall();
    int bad = 0;
    int fall_cyc;
    clear_rec_a();
    force_empty_a = 1'b1;
    load_a(8'h55); load_a(8'h66); load_a(8'h77); load_a(8'h88);
    out_ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_read_a !== 1'b0 || u_dut_a.state !== ST_REQ) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_req: %0d cycles with read or non-REQ state, required 0", bad);
    end
    tick();
    force_empty_a = 1'b0;
    fall_cyc = cyc;
    wait_done_a(100, "stall");
    n_cmp++;
    if (rd_cyc_a.size() != 4 || rd_cyc_a[0] != fall_cyc) begin
      n_err++;
      $display("FAIL stall_first_read: %0d reads, first not at empty fall cycle %0d, required 4 and match",
               rd_cyc_a.size(), fall_cyc);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_rec_a();
    out_ready_a = 1'b0;
    load_a(8'h5A); load_a(8'h6B); load_a(8'h7C); load_a(8'h8D);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_valid_a(20, "bp_valid");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid_a !== 1'b1 || out_data_a !== 8'h5A || wc_a !== 10'd0 || rd_cyc_a.size() != 1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0 (data %h wc %0d reads %0d)",
               bad, out_data_a, wc_a, rd_cyc_a.size());
    end
    tick();
    out_ready_a = 1'b1;
    wait_done_a(100, "bp");
    n_cmp++;
    if (wc_a !== 10'd4 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL bp_end: wc %0d left %0d, required 4 and 0", wc_a, exp_a.size());
    end
    tick();
  endtask

  task automatic test_gap0_ignore_start();
    bit ok;
    int k = 0;
    rd_cyc_b.delete(); hs_cyc_b.delete(); done_cyc_b.delete();
    load_b(8'h31, 1); load_b(8'h32, 1); load_b(8'h33, 1);
    load_b(8'hE1, 0); load_b(8'hE2, 0);
    out_ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (3) tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (done_cyc_b.size() == 0 && k < 100) begin
      tick();
      k++;
    end
    repeat (12) tick();
    ok = (rd_cyc_b.size() == 3);
    if (ok) for (int i = 1; i < 3; i++) if (rd_cyc_b[i] - rd_cyc_b[i-1] != 3) ok = 0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL gap0_reads: %0d reads, required 3 reads 3 cycles apart", rd_cyc_b.size());
    end
    n_cmp++;
    if (hs_cyc_b.size() != 3 || done_cyc_b.size() != 1 || wc_b !== 10'd3 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL gap0_result: handshakes %0d dones %0d wc %0d busy %b, required 3 1 3 0",
               hs_cyc_b.size(), done_cyc_b.size(), wc_b, busy_b);
    end
    n_cmp++;
    if (viol_b != 0 || viol_a != 0) begin
      n_err++;
      $display("FAIL read_while_empty: a %0d b %0d, required 0 0", viol_a, viol_b);
    end
    mem_b.delete();
    push_cnt_b = pop_cnt_b;
  endtask

  task automatic test_reset_mid();
    clear_rec_a();
    out_ready_a = 1'b0;
    load_a(8'hC1); load_a(8'hC2); load_a(8'hC3); load_a(8'hC4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_valid_a(20, "rm_word1");
    tick();
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    wait_valid_a(20, "rm_word2");
    n_cmp++;
    if (wc_a !== 10'd1 || out_data_a !== 8'hC2) begin
      n_err++;
      $display("FAIL rm_hold2: wc %0d data %h, required 1 c2", wc_a, out_data_a);
    end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({fifo_read_a, out_valid_a, busy_a, done_a, wc_a, out_data_a} !== 22'd0 ||
        u_dut_a.state !== ST_IDLE) begin
      n_err++;
      $display("FAIL rm_reset: outputs %h state %0d, required 0 and IDLE",
               {fifo_read_a, out_valid_a, busy_a, done_a, wc_a, out_data_a}, u_dut_a.state);
    end
    tick();
    rst = 1'b0;
    mem_a.delete();
    exp_a.delete();
    push_cnt_a = pop_cnt_a;
    clear_rec_a();
    tick();
    load_a(8'hD1); load_a(8'hD2); load_a(8'hD3); load_a(8'hD4);
    out_ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if (wc_a !== 10'd0 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL rm_restart: wc %0d busy %b, required 0 1", wc_a, busy_a);
    end
    wait_done_a(100, "rm");
    n_cmp++;
    if (wc_a !== 10'd4 || rd_cyc_a.size() != 4 || exp_a.size() != 0) begin
      n_err++;
      $display("FAIL rm_full: wc %0d reads %0d left %0d, required 4 4 0", wc_a, rd_cyc_a.size(), exp_a.size());
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; force_empty_a = 1'b0; out_ready_a = 1'b0;
    start_b = 1'b0; out_ready_b = 1'b0;
    test_reset();
    test_burst();
    test_empty_stall();
    test_backpressure();
    test_gap0_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
